// File: rtl/lcd_text_pkg.sv
// Shared definitions for the LCD character-cell text path: screen geometry,
// control character codes and the console writer FSM encoding.
package lcd_text_pkg;

    localparam int unsigned COLS_DEF   = 60;
    localparam int unsigned ROWS_DEF   = 17;
    localparam int unsigned ADDR_W_DEF = 10;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;

    typedef enum logic [1:0] {
        ST_CLR_ALL  = 2'd0,
        ST_CLR_LINE = 2'd1,
        ST_IDLE     = 2'd2
    } console_state_e;

    // Printable ASCII range that lands in the character RAM verbatim.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream console feeder: decodes printable ASCII plus CR/LF/BS/FF, tracks
// the cursor and issues single-cycle writes (including clears) into char RAM.
module text_console_writer
    import lcd_text_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [5:0]        cur_col,
    output logic [4:0]        cur_row,
    output logic              busy
);

    localparam logic [5:0]        COL_LAST   = 6'(COLS - 1);
    localparam logic [4:0]        ROW_LAST   = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] SWEEP_ALL  = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] SWEEP_LINE = ADDR_W'(COLS - 1);

    console_state_e    state;
    logic [ADDR_W-1:0] sweep;
    logic [ADDR_W-1:0] row_base;

    logic [ADDR_W-1:0] cell_addr;
    logic              row_last;
    logic [4:0]        adv_row;
    logic [ADDR_W-1:0] adv_base;

    // Cursor address without a multiplier: row_base steps by COLS per row.
    assign cell_addr = row_base + ADDR_W'(cur_col);
    assign row_last  = (cur_row == ROW_LAST);
    assign adv_row   = row_last ? 5'd0 : cur_row + 5'd1;
    assign adv_base  = row_last ? '0 : row_base + ROW_STEP;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_CLR_ALL;
            sweep    <= '0;
            row_base <= '0;
            cur_col  <= 6'd0;
            cur_row  <= 5'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_CLR_ALL: begin
                    wr_en   <= 1'b1;
                    wr_addr <= sweep;
                    wr_data <= CH_SPACE;
                    if (sweep == SWEEP_ALL) begin
                        sweep    <= '0;
                        row_base <= '0;
                        cur_col  <= 6'd0;
                        cur_row  <= 5'd0;
                        state    <= ST_IDLE;
                    end else begin
                        sweep <= sweep + ADDR_W'(1);
                    end
                end

                // Cursor already points at the new row; only its cells are blanked.
                ST_CLR_LINE: begin
                    wr_en   <= 1'b1;
                    wr_addr <= row_base + sweep;
                    wr_data <= CH_SPACE;
                    if (sweep == SWEEP_LINE) begin
                        sweep <= '0;
                        state <= ST_IDLE;
                    end else begin
                        sweep <= sweep + ADDR_W'(1);
                    end
                end

                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_printable(in_data)) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cell_addr;
                            wr_data <= in_data;
                            if (cur_col == COL_LAST) begin
                                cur_col  <= 6'd0;
                                cur_row  <= adv_row;
                                row_base <= adv_base;
                                sweep    <= '0;
                                state    <= ST_CLR_LINE;
                            end else begin
                                cur_col <= cur_col + 6'd1;
                            end
                        end else begin
                            case (in_data)
                                CH_CR: cur_col <= 6'd0;
                                CH_LF: begin
                                    cur_row  <= adv_row;
                                    row_base <= adv_base;
                                    sweep    <= '0;
                                    state    <= ST_CLR_LINE;
                                end
                                CH_BS: begin
                                    if (cur_col != 6'd0) begin
                                        cur_col <= cur_col - 6'd1;
                                        wr_en   <= 1'b1;
                                        wr_addr <= cell_addr - ADDR_W'(1);
                                        wr_data <= CH_SPACE;
                                    end
                                end
                                CH_FF: begin
                                    cur_col  <= 6'd0;
                                    cur_row  <= 5'd0;
                                    row_base <= '0;
                                    sweep    <= '0;
                                    state    <= ST_CLR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                default: begin
                    sweep <= '0;
                    state <= ST_CLR_ALL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer on a 4x3 screen: vector table for
// single-byte decode plus hand sequences for clears, wrap and reset mid-clear.
module tb_text_console_writer;

    localparam int unsigned COLS   = 4;
    localparam int unsigned ROWS   = 3;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [5:0]        cur_col;
    logic [4:0]        cur_row;
    logic              busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic       exp_wr;
        int         exp_addr;
        logic [7:0] exp_wd;
        int         exp_col;
        int         exp_row;
    } vec_t;

    vec_t vecs[11];

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Present a byte, wait for acceptance, return at the negedge where its write is visible.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic expect_write(input string name, input int addr, input int data);
        chk({name, "_wr_en"}, int'(wr_en), 1);
        chk({name, "_addr"}, int'(wr_addr), addr);
        chk({name, "_data"}, int'(wr_data), data);
    endtask

    task automatic expect_cursor(input string name, input int col, input int row);
        chk({name, "_col"}, int'(cur_col), col);
        chk({name, "_row"}, int'(cur_row), row);
    endtask

    // Expect n contiguous space writes from start, busy throughout, then ready.
    task automatic expect_clear(input string name, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            chk({name, "_busy"}, int'(busy), 1);
            @(negedge clk);
            expect_write(name, start + i, 8'h20);
        end
        chk({name, "_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'h08, 1'b0, 0, 8'h00, 0, 0};
        vecs[1]  = '{8'h58, 1'b1, 0, 8'h58, 1, 0};
        vecs[2]  = '{8'h08, 1'b1, 0, 8'h20, 0, 0};
        vecs[3]  = '{8'h07, 1'b0, 0, 8'h00, 0, 0};
        vecs[4]  = '{8'h7E, 1'b1, 0, 8'h7E, 1, 0};
        vecs[5]  = '{8'h7F, 1'b0, 0, 8'h00, 1, 0};
        vecs[6]  = '{8'h1F, 1'b0, 0, 8'h00, 1, 0};
        vecs[7]  = '{8'h20, 1'b1, 1, 8'h20, 2, 0};
        vecs[8]  = '{8'h0D, 1'b0, 0, 8'h00, 0, 0};
        vecs[9]  = '{8'h51, 1'b1, 0, 8'h51, 1, 0};
        vecs[10] = '{8'h0D, 1'b0, 0, 8'h00, 0, 0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        expect_cursor("rst", 0, 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 1);

        // Power-on screen clear
        rst_n = 1'b1;
        expect_clear("clr_all", 0, 12);
        expect_cursor("clr_all_cur", 0, 0);

        // Back-to-back "ABC"
        send(8'h41); expect_write("abc_a", 0, 8'h41);
        send(8'h42); expect_write("abc_b", 1, 8'h42);
        send(8'h43); expect_write("abc_c", 2, 8'h43);
        in_valid = 1'b0;
        expect_cursor("abc_cur", 3, 0);
        send(8'h0D);
        chk("cr_no_wr", int'(wr_en), 0);
        expect_cursor("cr_cur", 0, 0);

        // "ABCDE": wrap at last column, line clear, E held during clear
        send(8'h41); send(8'h42); send(8'h43);
        send(8'h44); expect_write("wrap_d", 3, 8'h44);
        in_data = 8'h45;
        expect_cursor("wrap_cur_during", 0, 1);
        expect_clear("clr_line1", 4, 4);
        @(negedge clk);
        expect_write("held_e", 4, 8'h45);
        in_valid = 1'b0;
        expect_cursor("held_e_cur", 1, 1);

        // LF to row 2, then LF wraps to row 0; col is preserved
        send(8'h0A);
        in_valid = 1'b0;
        expect_cursor("lf_row2_cur", 1, 2);
        expect_clear("clr_line2", 8, 4);
        send(8'h0A);
        in_valid = 1'b0;
        expect_cursor("lf_wrap_cur", 1, 0);
        expect_clear("clr_line0", 0, 4);
        send(8'h0D);
        in_valid = 1'b0;
        chk("cr2_no_wr", int'(wr_en), 0);
        expect_cursor("cr2_cur", 0, 0);

        // Single-byte decode table starting at (0,0)
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].data);
            chk($sformatf("vec%0d_wr_en", i), int'(wr_en), int'(vecs[i].exp_wr));
            if (vecs[i].exp_wr) begin
                chk($sformatf("vec%0d_addr", i), int'(wr_addr), vecs[i].exp_addr);
                chk($sformatf("vec%0d_data", i), int'(wr_data), int'(vecs[i].exp_wd));
            end
            expect_cursor($sformatf("vec%0d", i), vecs[i].exp_col, vecs[i].exp_row);
        end
        in_valid = 1'b0;

        // FF mid-screen, then reset pulse during the clear
        send(8'h5A); expect_write("ff_pre_z", 0, 8'h5A);
        send(8'h0A);
        in_valid = 1'b0;
        expect_clear("ff_pre_lf", 4, 4);
        expect_cursor("ff_pre_cur", 1, 1);
        send(8'h0C);
        in_valid = 1'b0;
        chk("ff_no_wr", int'(wr_en), 0);
        chk("ff_busy", int'(busy), 1);
        expect_cursor("ff_cur", 0, 0);
        @(negedge clk); expect_write("ff_clr0", 0, 8'h20);
        @(negedge clk); expect_write("ff_clr1", 1, 8'h20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_busy", int'(busy), 1);
        rst_n = 1'b1;
        expect_clear("clr_restart", 0, 12);
        expect_cursor("restart_cur", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
